// File: rtl/ntt_cmd_pkg.sv
// Shared definitions for the NTT command dispatcher: opcodes, instruction
// field positions, sequencer states and the opcode legality check.
package ntt_cmd_pkg;

  localparam int INSTR_W = 64;

  localparam logic [7:0] OPC_LOAD  = 8'h02;
  localparam logic [7:0] OPC_STORE = 8'h03;
  localparam logic [7:0] OPC_COPY  = 8'h04;
  localparam logic [7:0] OPC_NTT   = 8'h10;
  localparam logic [7:0] OPC_INTT  = 8'h11;
  localparam logic [7:0] OPC_ADD   = 8'h20;
  localparam logic [7:0] OPC_SUB   = 8'h21;
  localparam logic [7:0] OPC_MULT  = 8'h22;

  localparam int OPC_MSB     = 63;
  localparam int OPC_LSB     = 56;
  localparam int SLOT_MSB    = 55;
  localparam int SLOT_LSB    = 52;
  localparam int RSVD_MSB    = 51;
  localparam int RSVD_LSB    = 48;
  localparam int ADDR_MSB    = 47;
  localparam int ADDR_LSB    = 0;
  // ALU ops reuse the top of dma_addr as the source slot; the engine decodes it.
  localparam int ALU_SRC_MSB = 47;
  localparam int ALU_SRC_LSB = 46;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  function automatic logic is_legal_opcode(input logic [7:0] opc);
    case (opc)
      OPC_LOAD, OPC_STORE, OPC_COPY, OPC_NTT,
      OPC_INTT, OPC_ADD, OPC_SUB, OPC_MULT: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ntt_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO holding queued instruction words.
// Push is ignored when full, pop is ignored when empty.
module ntt_cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ntt_cmd_dispatcher.sv
// Command queue and sequencer feeding the NTT engine one instruction at a time.
// Build option: define NTT_CMDQ_OPCHECK_EN to drop illegal opcodes in IDLE
// and raise the sticky err_illegal flag; otherwise every word is issued.
//
// state     | meaning
// IDLE      | pop queue head into the cmd_* holding registers
// ISSUE     | cmd_valid high until the engine is sampled ready
// WAIT_ACK  | engine took the command; wait for it to drop ready
// WAIT_DONE | engine working; ready rising retires the command
module ntt_cmd_dispatcher #(
  parameter int DEPTH     = 16,
  parameter int DEPTH_LOG = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [63:0]          in_instr,
  output logic                 cmd_valid,
  output logic [7:0]           cmd_opcode,
  output logic [3:0]           cmd_slot,
  output logic [47:0]          cmd_dma_addr,
  input  logic                 eng_ready,
  output logic                 busy,
  output logic [DEPTH_LOG:0]   count,
  output logic [15:0]          retired,
  output logic                 err_illegal
);

  import ntt_cmd_pkg::*;

  state_e        state_q, state_d;
  logic [7:0]    opc_q, opc_d;
  logic [3:0]    slot_q, slot_d;
  logic [47:0]   addr_q, addr_d;
  logic [15:0]   retired_q, retired_d;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [63:0]   fifo_head;
  logic [7:0]    head_opc;
  logic [3:0]    head_slot;
  logic [47:0]   head_addr;
  logic [3:0]    unused_rsvd;

  ntt_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .wdata (in_instr),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_opc    = fifo_head[OPC_MSB:OPC_LSB];
  assign head_slot   = fifo_head[SLOT_MSB:SLOT_LSB];
  assign head_addr   = fifo_head[ADDR_MSB:ADDR_LSB];
  assign unused_rsvd = fifo_head[RSVD_MSB:RSVD_LSB];

  assign in_ready     = ~fifo_full;
  assign cmd_valid    = (state_q == ST_ISSUE);
  assign cmd_opcode   = opc_q;
  assign cmd_slot     = slot_q;
  assign cmd_dma_addr = addr_q;
  assign retired      = retired_q;
  assign busy         = ~fifo_empty | (state_q != ST_IDLE);

`ifdef NTT_CMDQ_OPCHECK_EN
  logic err_q, err_d;
  assign err_illegal = err_q;
`else
  assign err_illegal = 1'b0;
`endif

  // Next-state, head pop and holding-register loads; fields only move on IDLE->ISSUE.
  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    slot_d    = slot_q;
    addr_d    = addr_q;
    retired_d = retired_q;
    fifo_pop  = 1'b0;
`ifdef NTT_CMDQ_OPCHECK_EN
    err_d     = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
`ifdef NTT_CMDQ_OPCHECK_EN
          if (!is_legal_opcode(head_opc)) begin
            err_d = 1'b1;
          end else begin
            opc_d   = head_opc;
            slot_d  = head_slot;
            addr_d  = head_addr;
            state_d = ST_ISSUE;
          end
`else
          opc_d   = head_opc;
          slot_d  = head_slot;
          addr_d  = head_addr;
          state_d = ST_ISSUE;
`endif
        end
      end
      ST_ISSUE: begin
        if (eng_ready) state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (!eng_ready) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (eng_ready) begin
          retired_d = retired_q + 16'd1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and holding registers; reset aborts any in-flight command uncounted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      opc_q     <= '0;
      slot_q    <= '0;
      addr_q    <= '0;
      retired_q <= '0;
`ifdef NTT_CMDQ_OPCHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      slot_q    <= slot_d;
      addr_q    <= addr_d;
      retired_q <= retired_d;
`ifdef NTT_CMDQ_OPCHECK_EN
      err_q     <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_ntt_cmd_dispatcher.sv
// Bench for ntt_cmd_dispatcher: directed vector table, engine stall/fill/reset
// sequences and a randomized run against an in-order command scoreboard.
module tb_ntt_cmd_dispatcher;

  localparam int DEPTH = 16;
`ifdef NTT_CMDQ_OPCHECK_EN
  localparam bit OPCHECK = 1'b1;
`else
  localparam bit OPCHECK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_instr;
  logic        cmd_valid;
  logic [7:0]  cmd_opcode;
  logic [3:0]  cmd_slot;
  logic [47:0] cmd_dma_addr;
  logic        eng_ready;
  logic        busy;
  logic [4:0]  count;
  logic [15:0] retired;
  logic        err_illegal;

  ntt_cmd_dispatcher #(.DEPTH(16), .DEPTH_LOG(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .cmd_valid    (cmd_valid),
    .cmd_opcode   (cmd_opcode),
    .cmd_slot     (cmd_slot),
    .cmd_dma_addr (cmd_dma_addr),
    .eng_ready    (eng_ready),
    .busy         (busy),
    .count        (count),
    .retired      (retired),
    .err_illegal  (err_illegal)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0]  opc;
    logic [3:0]  slot;
    logic [47:0] addr;
  } cmd_t;

  cmd_t exp_q[$];
  int   exp_issued = 0;
  bit   model_err  = 1'b0;

  logic [7:0] legal_list [8] = '{8'h02, 8'h03, 8'h04, 8'h10, 8'h11, 8'h20, 8'h21, 8'h22};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [7:0] o);
    return o inside {8'h02, 8'h03, 8'h04, 8'h10, 8'h11, 8'h20, 8'h21, 8'h22};
  endfunction

  // Reference: accepted words come out in order, minus dropped illegal ones.
  task automatic model_accept(input logic [63:0] w);
    cmd_t c;
    c.opc  = w[63:56];
    c.slot = w[55:52];
    c.addr = w[47:0];
    if (!OPCHECK || legal(c.opc)) begin
      exp_q.push_back(c);
      exp_issued++;
    end else begin
      model_err = 1'b1;
    end
  endtask

  // Engine model: drops ready after taking a strobe, stays busy a random time.
  bit eng_manual = 1'b0;
  int eng_lat_max = 0;
  int eng_cnt = 0;
  bit acc_pend = 1'b0;

  always @(negedge clk) acc_pend = cmd_valid && eng_ready && !rst;

  always @(posedge clk) begin
    #1;
    if (!eng_manual) begin
      if (rst) begin
        eng_ready = 1'b1;
        eng_cnt   = 0;
      end else if (acc_pend) begin
        eng_ready = 1'b0;
        eng_cnt   = int'($urandom_range(eng_lat_max, 0));
      end else if (!eng_ready) begin
        if (eng_cnt > 0) eng_cnt--;
        else eng_ready = 1'b1;
      end
    end
  end

  // Monitor: strobe contents vs scoreboard, field stability, strobe width, in_ready.
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] last_opc = '0;
  logic [3:0] last_slot = '0;
  logic [47:0] last_addr = '0;
  cmd_t       mon_e;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      last_opc   = '0;
      last_slot  = '0;
      last_addr  = '0;
    end else begin
      if (cmd_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_strobe: opcode 0x%0h issued, none expected (t=%0t)", cmd_opcode, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("strobe_opcode", cmd_opcode, mon_e.opc);
          chk("strobe_slot", cmd_slot, mon_e.slot);
          chk("strobe_addr", cmd_dma_addr, mon_e.addr);
        end
      end else begin
        chk("hold_fields", {cmd_opcode, cmd_slot, cmd_dma_addr}, {last_opc, last_slot, last_addr});
      end
      if (prev_valid && prev_ready) chk("strobe_width", cmd_valid, 0);
      chk("in_ready_vs_count", in_ready, (count < DEPTH));
      prev_valid = cmd_valid;
      prev_ready = eng_ready;
      last_opc   = cmd_opcode;
      last_slot  = cmd_slot;
      last_addr  = cmd_dma_addr;
    end
  end

  task automatic push(input logic [63:0] w, input int budget);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = w;
    while (!in_ready && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL push_timeout: in_ready 0, required 1 within %0d cycles", budget);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_accept(w);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int t = 0;
    @(negedge clk);
    while (busy && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk(name, busy, 0);
  endtask

  task automatic wait_strobe(input string name, input int budget);
    int t = 0;
    @(negedge clk);
    while (!cmd_valid && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk(name, cmd_valid, 1);
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_issued = 0;
    model_err  = 1'b0;
  endtask

  // Strobe held with engine not ready: valid and fields stay, drop after ready.
  task automatic stall_cmd(input logic [63:0] w, input int n, input logic [47:0] exp_addr);
    eng_manual = 1'b1;
    @(negedge clk);
    eng_ready = 1'b0;
    push(w, 50);
    wait_strobe("stall_strobe", 20);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("stall_valid", cmd_valid, 1);
      chk("stall_addr", cmd_dma_addr, exp_addr);
    end
    eng_ready = 1'b1;
    @(negedge clk);
    chk("valid_drop", cmd_valid, 0);
    eng_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("stall_no_retire_yet", retired, 16'(exp_issued - 1));
    eng_ready = 1'b1;
    eng_cnt = 0;
    eng_manual = 1'b0;
    wait_idle("stall_idle", 50);
    chk("stall_retired", retired, 16'(exp_issued));
  endtask

  typedef struct {
    logic [63:0] instr;
    logic [7:0]  opc;
    logic [3:0]  slot;
    logic [47:0] addr;
    bit          is_legal;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [63:0] w;
    logic [7:0]  o;
    bit          exp_issue;

    vecs[0]  = '{64'h10_1_0_0000_0000_0000, 8'h10, 4'h1, 48'h0000_0000_0000, 1'b1};
    vecs[1]  = '{64'h02_3_0_0000_0000_1000, 8'h02, 4'h3, 48'h0000_0000_1000, 1'b1};
    vecs[2]  = '{64'h20_5_0_8000_0000_0abc, 8'h20, 4'h5, 48'h8000_0000_0abc, 1'b1};
    vecs[3]  = '{64'h7f_2_0_0000_0000_0055, 8'h7f, 4'h2, 48'h0000_0000_0055, 1'b0};
    vecs[4]  = '{64'h20_6_0_4000_0000_0001, 8'h20, 4'h6, 48'h4000_0000_0001, 1'b1};
    vecs[5]  = '{64'h22_f_0_ffff_ffff_ffff, 8'h22, 4'hf, 48'hffff_ffff_ffff, 1'b1};
    vecs[6]  = '{64'h11_0_0_1234_5678_9abc, 8'h11, 4'h0, 48'h1234_5678_9abc, 1'b1};
    vecs[7]  = '{64'h00_9_0_0000_0000_0000, 8'h00, 4'h9, 48'h0000_0000_0000, 1'b0};
    vecs[8]  = '{64'h04_7_f_0000_dead_beef, 8'h04, 4'h7, 48'h0000_dead_beef, 1'b1};
    vecs[9]  = '{64'h21_a_5_c000_0000_0000, 8'h21, 4'ha, 48'hc000_0000_0000, 1'b1};
    vecs[10] = '{64'h03_b_0_0000_0000_0100, 8'h03, 4'hb, 48'h0000_0000_0100, 1'b1};
    vecs[11] = '{64'hff_4_0_0000_0000_0002, 8'hff, 4'h4, 48'h0000_0000_0002, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    eng_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_count", count, 0);
    rst = 1'b0;
    clear_model();

    // Reset state
    @(negedge clk);
    chk("reset_cmd_valid", cmd_valid, 0);
    chk("reset_fields", {cmd_opcode, cmd_slot, cmd_dma_addr}, 0);
    chk("reset_count", count, 0);
    chk("reset_retired", retired, 0);
    chk("reset_err", err_illegal, 0);
    chk("reset_busy", busy, 0);
    chk("reset_in_ready", in_ready, 1);

    // Directed vector table, one word at a time into an idle queue
    for (int i = 0; i < 12; i++) begin
      exp_issue = vecs[i].is_legal || !OPCHECK;
      push(vecs[i].instr, 50);
      @(negedge clk);
      chk("lat_after_accept", cmd_valid, 0);
      chk("busy_after_accept", busy, 1);
      @(negedge clk);
      chk("lat_after_pop", cmd_valid, exp_issue);
      if (exp_issue) begin
        chk("vec_opcode", cmd_opcode, vecs[i].opc);
        chk("vec_slot", cmd_slot, vecs[i].slot);
        chk("vec_addr", cmd_dma_addr, vecs[i].addr);
      end
      wait_idle("vec_idle", 100);
      chk("vec_retired", retired, 16'(exp_issued));
      chk("vec_err", err_illegal, model_err);
      chk("vec_sb_empty", exp_q.size(), 0);
    end

    // Long engine stall: LOAD addr 0x1000, then ADD with ALU source slot 2
    stall_cmd(64'h02_1_0_0000_0000_1000, 50, 48'h0000_0000_1000);
    stall_cmd(64'h20_2_0_8000_0000_0040, 5, 48'h8000_0000_0040);

    // Fill: engine holds one command in WAIT_DONE while 16 more queue up
    eng_manual = 1'b1;
    eng_ready  = 1'b1;
    push(64'h10_e_0_0000_0000_0077, 50);
    wait_strobe("fill_first_strobe", 20);
    @(negedge clk);
    eng_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      w = {legal_list[i % 8], 4'(i), 4'h0, 48'(i * 16'h0101)};
      push(w, 0);
    end
    @(negedge clk);
    chk("fill_count", count, 16);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_busy", busy, 1);
    in_valid = 1'b1;
    in_instr = 64'h11_0_0_0000_0000_dead;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("held_off_count", count, 16);
      chk("held_off_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    eng_cnt = 0;
    eng_manual = 1'b0;
    wait_idle("fill_drain", 1000);
    chk("fill_retired", retired, 16'(exp_issued));
    chk("fill_sb_empty", exp_q.size(), 0);
    chk("fill_count_after", count, 0);

    // Reset during WAIT_DONE with three words queued
    eng_manual = 1'b1;
    eng_ready  = 1'b1;
    push(64'h21_1_0_0000_0000_0011, 50);
    wait_strobe("rst_seq_strobe", 20);
    @(negedge clk);
    eng_ready = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) push({8'h22, 4'(i), 4'h0, 48'h100 + 48'(i)}, 0);
    @(negedge clk);
    chk("pre_rst_count", count, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_now_count", count, 0);
    chk("rst_now_valid", cmd_valid, 0);
    chk("rst_now_retired", retired, 0);
    chk("rst_now_busy", busy, 0);
    chk("rst_now_in_ready", in_ready, 1);
    clear_model();
    repeat (2) @(negedge clk);
    eng_ready  = 1'b1;
    eng_manual = 1'b0;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_retired", retired, 0);
    chk("post_rst_count", count, 0);

    // Randomized traffic with random engine latency
    eng_lat_max = 5;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(2, 0)) @(negedge clk);
      o = ($urandom_range(3, 0) != 0) ? legal_list[$urandom_range(7, 0)] : 8'($urandom);
      w = {o, 4'($urandom), 4'($urandom), 16'($urandom), 32'($urandom)};
      push(w, 2000);
    end
    wait_idle("rand_drain", 5000);
    chk("rand_retired", retired, 16'(exp_issued));
    chk("rand_sb_empty", exp_q.size(), 0);
    chk("rand_err", err_illegal, model_err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
